// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide: one radix-2 step per clock, fixed 32-cycle latency.
// Define MULDIV_SIGNED_EN to honour sgn (two's-complement via magnitude conversion and sign fix-up).
module mul_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic        sgn,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [1:0]  op_q;
   logic        busy_q, done_q;
   logic [31:0] result_q;
   // hi_q: partial product high word / partial remainder; lo_q: multiplier / quotient bits
   logic [31:0] hi_q, lo_q, dvs_q;
   logic [31:0] hi_d, lo_d, result_d;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_acc, div_r, div_trial;
   logic [63:0] prod;
   logic [31:0] quo, rem;

`ifdef MULDIV_SIGNED_EN
   logic a_neg, b_neg, negp_d, negp_q, negr_q;

   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction
`else
   logic unused_sgn;
   assign unused_sgn = sgn;
`endif

   always_comb begin
`ifdef MULDIV_SIGNED_EN
      a_neg  = sgn & a[31];
      b_neg  = sgn & b[31];
      mag_a  = a_neg ? neg32(a) : a;
      mag_b  = b_neg ? neg32(b) : b;
      // A zero divisor keeps the all-ones quotient unsigned
      negp_d = (a_neg ^ b_neg) & (~op[1] | (|b));
`else
      mag_a  = a;
      mag_b  = b;
`endif
   end

   always_comb begin
      mul_acc   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, dvs_q}) : {1'b0, hi_q};
      div_r     = {hi_q, lo_q[31]};
      div_trial = div_r - {1'b0, dvs_q};
      if (!op_q[1]) begin
         {hi_d, lo_d} = {mul_acc, lo_q[31:1]};
      end else if (!div_trial[32]) begin
         hi_d = div_trial[31:0];
         lo_d = {lo_q[30:0], 1'b1};
      end else begin
         hi_d = div_r[31:0];
         lo_d = {lo_q[30:0], 1'b0};
      end

`ifdef MULDIV_SIGNED_EN
      prod = negp_q ? (~{hi_d, lo_d} + 64'd1) : {hi_d, lo_d};
      quo  = negp_q ? neg32(lo_d) : lo_d;
      rem  = negr_q ? neg32(hi_d) : hi_d;
`else
      prod = {hi_d, lo_d};
      quo  = lo_d;
      rem  = hi_d;
`endif

      case (op_q)
         2'd0:    result_d = prod[31:0];
         2'd1:    result_d = prod[63:32];
         2'd2:    result_d = quo;
         default: result_d = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  op_q    <= op;
                  hi_q    <= 32'd0;
                  lo_q    <= op[1] ? mag_a : mag_b;
                  dvs_q   <= op[1] ? mag_b : mag_a;
`ifdef MULDIV_SIGNED_EN
                  negp_q  <= negp_d;
                  negr_q  <= a_neg;
`endif
                  cnt_q   <= 5'd0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  result_q <= result_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, results, reset abort and start-ignore behaviour.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic        sgn = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   mul_div_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Drives one operation and observes it; k counts edges after the start edge E0.
   task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input logic s_i, input bit repulse,
                         output logic [31:0] res, output logic [31:0] res_late,
                         output int done_cycle, output int done_count, output bit busy_ok);
      op = op_i; a = a_i; b = b_i; sgn = s_i; start = 1'b1;
      done_count = 0; done_cycle = -1; busy_ok = 1'b1; res = 32'hDEAD_BEEF;
      for (int k = 0; k <= 34; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            start = 1'b0;
            a = ~a_i; b = b_i ^ 32'h5A5A_0F0F; op = ~op_i; sgn = ~s_i;
         end
         if (repulse && (k == 4 || k == 21 || k == 33)) start = 1'b0;
         if (repulse && (k == 3 || k == 20 || k == 32)) start = 1'b1;
         if (done === 1'b1) begin done_count++; done_cycle = k; end
         if (busy !== (k <= 32)) busy_ok = 1'b0;
         if (k == 32) res = result;
      end
      start = 1'b0;
      res_late = result;
   endtask

   task automatic check_op(input string name, input logic [1:0] op_i, input logic [31:0] a_i,
                           input logic [31:0] b_i, input logic s_i, input logic [31:0] exp);
      logic [31:0] res, res_late;
      int dc, dn;
      bit bok;
      run_op(op_i, a_i, b_i, s_i, 1'b0, res, res_late, dc, dn, bok);
      checks++;
      if (res !== exp) begin
         errors++; $display("FAIL %s result got %h expected %h", name, res, exp);
      end
      checks++;
      if (dc !== 32 || dn !== 1) begin
         errors++; $display("FAIL %s done at %0d count %0d expected at 32 count 1", name, dc, dn);
      end
      checks++;
      if (!bok) begin
         errors++; $display("FAIL %s busy window got wrong expected E0..E32", name);
      end
      checks++;
      if (res_late !== exp) begin
         errors++; $display("FAIL %s result_hold got %h expected %h", name, res_late, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
         errors++; $display("FAIL reset got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
      end
      rst = 1'b0;
   endtask

   task automatic test_mul();
      check_op("mul_ff",  2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001);
      check_op("mulh_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE);
      check_op("mul_x2",  2'd0, 32'hFFFF_FFFF, 32'd2,         1'b0, 32'hFFFF_FFFE);
      check_op("mulh_x2", 2'd1, 32'hFFFF_FFFF, 32'd2,         1'b0, 32'h0000_0001);
      check_op("mul_3x5", 2'd0, 32'd3,         32'd5,         1'b0, 32'd15);
      check_op("mulh_2p32", 2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001);
   endtask

   task automatic test_div();
      check_op("div_100_7", 2'd2, 32'd100, 32'd7, 1'b0, 32'd14);
      check_op("rem_100_7", 2'd3, 32'd100, 32'd7, 1'b0, 32'd2);
      check_op("div_big",   2'd2, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF);
      check_op("rem_big",   2'd3, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0000_000F);
      check_op("div_eq",    2'd2, 32'd1000, 32'd1000, 1'b0, 32'd1);
   endtask

   task automatic test_div_zero();
      check_op("div_by0", 2'd2, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF);
      check_op("rem_by0", 2'd3, 32'd5, 32'd0, 1'b0, 32'h0000_0005);
   endtask

   task automatic test_reset_abort();
      int dn;
      op = 2'd2; a = 32'd100; b = 32'd7; sgn = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || result !== 32'd0 || done !== 1'b0) begin
         errors++; $display("FAIL abort got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
      end
      rst = 1'b0;
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dn++;
      end
      checks++;
      if (dn !== 0) begin
         errors++; $display("FAIL abort_nodone got %0d pulses expected 0", dn);
      end
      check_op("after_abort", 2'd0, 32'd3, 32'd5, 1'b0, 32'd15);
      // reset wins over start on the same edge
      start = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || result !== 32'd0) begin
         errors++; $display("FAIL rst_prio got busy=%b result=%h expected 0 0", busy, result);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res, res_late;
      int dc, dn;
      bit bok;
      run_op(2'd2, 32'd100, 32'd7, 1'b0, 1'b1, res, res_late, dc, dn, bok);
      checks++;
      if (res !== 32'd14 || res_late !== 32'd14) begin
         errors++; $display("FAIL repulse_result got %h/%h expected 0000000e", res, res_late);
      end
      checks++;
      if (dn !== 1 || dc !== 32) begin
         errors++; $display("FAIL repulse_done got count %0d at %0d expected 1 at 32", dn, dc);
      end
      checks++;
      if (!bok) begin
         errors++; $display("FAIL repulse_busy got extra or missing busy expected E0..E32 only");
      end
   endtask

   task automatic test_signed();
`ifdef MULDIV_SIGNED_EN
      check_op("sdiv_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
      check_op("srem_m7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
      check_op("sdiv_ovf",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
      check_op("srem_ovf",  2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
      check_op("sdiv_by0",  2'd2, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF);
      check_op("srem_by0",  2'd3, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB);
      check_op("smulh_m1",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
`else
      check_op("udiv_sgn1", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC);
      check_op("urem_sgn1", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h0000_0001);
      check_op("umulh_sgn1", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
`endif
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_reset_abort();
      test_back_to_back();
      test_signed();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock, shared with the ALUOut register stage.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 0 MUL (low 32 bits), 1 MULH (high 32 bits), 2 DIV (quotient), 3 REM (remainder).
REQ-006 sgn  input  1  signed-operation select; honoured only when MULDIV_SIGNED_EN is defined.
REQ-007 a  input  32  operand A (multiplicand or dividend).
REQ-008 b  input  32  operand B (multiplier or divisor).
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion strobe.
REQ-011 result  output  32  registered result; feeds the ALUresult input of the ALUOut register.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at edge E0: latch a, b, op and sgn; clear the iteration counter; go to RUN.
REQ-014 RUN: one radix-2 iteration per clock (shift-add multiply or restoring divide); 32 iterations on edges E1..E32; counter 5 bits, 0..31.
REQ-015 At E32 the block SHALL load result and go to DONE.
REQ-016 DONE: done=1 for exactly one cycle; return to IDLE at E33.
REQ-017 result SHALL stay stable from E32 until the next accepted start; it SHALL NOT be changed by operand or op changes after E0.
REQ-018 A start asserted while in RUN or DONE SHALL be ignored and not queued.
REQ-019 Latency SHALL be fixed at 32 cycles from the start edge to the result-valid edge, for every op and every operand value.
REQ-020 Multiply SHALL form a 64-bit product internally; MUL returns bits [31:0], MULH returns bits [63:32].
REQ-021 Unsigned divide by zero: DIV returns 0xFFFFFFFF and REM returns a, with no exception and the same latency.
REQ-022 Operands SHALL be sampled only at E0; a and b may change freely during RUN.

Reset
REQ-023 rst=1 at any edge SHALL force IDLE with busy=0, done=0, result=0x00000000 and counter=0, including during RUN or DONE; an operation interrupted by reset is abandoned.
REQ-024 rst SHALL take priority over start on the same edge.

Configuration
REQ-025 Macro MULDIV_SIGNED_EN defined: sgn=1 selects two's-complement operation via operand magnitude conversion at E0 and result sign fix-up at E32, within the same 32-cycle latency.
- Remainder sign follows the dividend.
- Signed divide by zero: DIV=0xFFFFFFFF, REM=a.
- 0x80000000 / 0xFFFFFFFF: DIV=0x80000000, REM=0.
REQ-026 Macro MULDIV_SIGNED_EN not defined: sgn SHALL be ignored, all operations are unsigned, and no sign-conversion logic is present.

Verification
REQ-027 MUL and MULH with a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0x00000001 and 0xFFFFFFFE respectively; done high exactly in the cycle after E32.
REQ-028 DIV and REM with a=100, b=7 -> 14 and 2; busy high from E0 through the DONE cycle.
REQ-029 DIV and REM with a=5, b=0 -> 0xFFFFFFFF and 0x00000005, at normal latency.
REQ-030 start, then rst at RUN iteration 10 -> busy=0 and result=0 after that edge; no done pulse; a new start then completes normally.
REQ-031 start re-pulsed at RUN iterations 3 and 20 and during the DONE cycle -> exactly one done pulse, result unchanged, no second operation.
REQ-032 DIV with a=0xFFFFFFF9 (-7), b=2, sgn=1 -> with MULDIV_SIGNED_EN: 0xFFFFFFFD and REM 0xFFFFFFFF; without it: 0x7FFFFFFC and REM 0x00000001.
